// File: rtl/booth_mult_arbiter_pkg.sv
// Shared defaults, tag format and helpers for the Booth multiplier arbiter.
package booth_mult_arbiter_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_W        = 32;
  localparam int DEF_MULT_LAT = 2;

  // Tag id field is sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  // Width of a requester index; never below one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester strictly after ptr.
module rr_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = id_w(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // Scan ptr+1 .. ptr+N (mod N) and keep the first hit.
  always_comb begin
    logic [IW-1:0] cand;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!grant_any && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Sequences one shared registered Booth multiplier among N requesters.
// The result register here is the final stage of the MULT_LAT latency: the
// external multiplier presents its product MULT_LAT-1 cycles after operands,
// and res_data/res_valid both appear MULT_LAT cycles after the grant.
module booth_mult_arbiter
  import booth_mult_arbiter_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int W        = DEF_W,
  parameter  int MULT_LAT = DEF_MULT_LAT,
  localparam int IW       = id_w(N),
  localparam int LW       = $clog2(MULT_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    res_valid,
  output logic [2*W-1:0]  res_data,
  output logic [IW-1:0]   res_id,
  output logic [LW-1:0]   inflight,
  output logic [W-1:0]    mult_a,
  output logic [W-1:0]    mult_b,
  input  logic [2*W-1:0]  mult_result
);

  tag_t          tag_pipe [MULT_LAT];
  tag_t          tag_in   [MULT_LAT];
  tag_t          tag_last;
  logic [N-1:0]  busy;
  logic [N-1:0]  busy_eff;
  logic [N-1:0]  eligible;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic [IW-1:0] ptr;

  assign tag_last = tag_pipe[MULT_LAT-1];

  // Returning requester is free again in its res_valid cycle.
  always_comb begin
    res_valid = '0;
    if (tag_last.vld) res_valid[tag_last.id[IW-1:0]] = 1'b1;
  end

  assign busy_eff = busy & ~res_valid;
  assign eligible = req_valid & ~busy_eff;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  // Operand mux: one-hot OR of the granted requester, zero when idle.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        mult_a = mult_a | req_a[i*W +: W];
        mult_b = mult_b | req_b[i*W +: W];
      end
    end
  end

  // Next value of every tag stage; stage 0 takes the current grant.
  always_comb begin
    tag_in[0].vld = grant_any;
    tag_in[0].id  = ID_MAX_W'(grant_idx);
    for (int k = 1; k < MULT_LAT; k++) tag_in[k] = tag_pipe[k-1];
  end

  // Count of valid tag stages.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < MULT_LAT; k++) inflight = inflight + LW'(tag_pipe[k].vld);
  end

  // Tag shift, busy tracking, rr pointer and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MULT_LAT; k++) tag_pipe[k] <= '0;
      busy     <= '0;
      ptr      <= IW'(N - 1);
      res_data <= '0;
      res_id   <= '0;
    end else begin
      for (int k = 0; k < MULT_LAT; k++) tag_pipe[k] <= tag_in[k];
      busy <= busy_eff | grant;
      if (grant_any) ptr <= grant_idx;
      if (tag_in[MULT_LAT-1].vld) begin
        res_data <= mult_result;
        res_id   <= tag_in[MULT_LAT-1].id[IW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter (N=4, W=32, MULT_LAT=2).
module tb_booth_mult_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     res_valid;
  logic [2*W-1:0]   res_data;
  logic [1:0]       res_id;
  logic [1:0]       inflight;
  logic [W-1:0]     mult_a;
  logic [W-1:0]     mult_b;
  logic [2*W-1:0]   mult_result;

  int checks   = 0;
  int failures = 0;

  booth_mult_arbiter #(.N(N), .W(W), .MULT_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_id      (res_id),
    .inflight    (inflight),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_result (mult_result)
  );

  always #5 clk = ~clk;

  // External multiplier stage; the arbiter's result register is the second stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mult_result <= '0;
    else     mult_result <= $signed({{W{mult_a[W-1]}}, mult_a}) * $signed({{W{mult_b[W-1]}}, mult_b});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Enter reset at a falling edge, leave it at the next one.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0001); end
    checks++; if (res_valid !== 4'b0000) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 64'h0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
    checks++; if (inflight !== 2'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    @(negedge clk);
    set_req(0, 32'd5, -32'sd7);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    checks++; if (mult_a !== 32'd5) begin failures++; $display("FAIL single_mult_a got=%h exp=5", mult_a); end
    checks++; if (mult_b !== 32'hFFFF_FFF9) begin failures++; $display("FAIL single_mult_b got=%h exp=fffffff9", mult_b); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (res_valid !== 4'b0000) begin failures++; $display("FAIL single_early got=%b exp=0000", res_valid); end
    checks++; if (inflight !== 2'd1) begin failures++; $display("FAIL single_inflight got=%0d exp=1", inflight); end
    @(negedge clk);
    #1;
    checks++; if (res_valid !== 4'b0001) begin failures++; $display("FAIL single_res_valid got=%b exp=0001", res_valid); end
    checks++; if (res_data !== 64'hFFFF_FFFF_FFFF_FFDD) begin failures++; $display("FAIL single_res_data got=%h exp=ffffffffffffffdd", res_data); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL single_res_id got=%0d exp=0", res_id); end
    @(negedge clk);
    #1;
    checks++; if (res_valid !== 4'b0000) begin failures++; $display("FAIL single_pulse got=%b exp=0000", res_valid); end
    checks++; if (res_data !== 64'hFFFF_FFFF_FFFF_FFDD) begin failures++; $display("FAIL single_hold got=%h exp=ffffffffffffffdd", res_data); end
  endtask

  localparam logic [3:0]  T2_VLD [7] = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  localparam logic [3:0]  T2_GNT [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  localparam logic [3:0]  T2_RV  [7] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
  localparam logic [63:0] T2_RD  [7] = '{64'd0, 64'd0, 64'd6, 64'd48, 64'hFFFF_FFFF_FFFF_FFD3, 64'd0, 64'd0};
  localparam logic [1:0]  T2_ID  [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  localparam logic [1:0]  T2_INF [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
  localparam logic [31:0] T2_MA  [7] = '{32'd2, 32'hFFFF_FFF4, 32'hFFFF_FFF7, 32'd11, 32'd0, 32'd0, 32'd0};

  task automatic test_all_four();
    apply_reset();
    set_req(0, 32'd2, 32'd3);
    set_req(1, -32'sd12, -32'sd4);
    set_req(2, -32'sd9, 32'd5);
    set_req(3, 32'd11, 32'd0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = T2_VLD[c];
      #1;
      checks++; if (req_ready !== T2_GNT[c]) begin failures++; $display("FAIL all4_ready c=%0d got=%b exp=%b", c, req_ready, T2_GNT[c]); end
      checks++; if (mult_a !== T2_MA[c]) begin failures++; $display("FAIL all4_mult_a c=%0d got=%h exp=%h", c, mult_a, T2_MA[c]); end
      checks++; if (res_valid !== T2_RV[c]) begin failures++; $display("FAIL all4_res_valid c=%0d got=%b exp=%b", c, res_valid, T2_RV[c]); end
      checks++; if (inflight !== T2_INF[c]) begin failures++; $display("FAIL all4_inflight c=%0d got=%0d exp=%0d", c, inflight, T2_INF[c]); end
      if (T2_RV[c] != 4'b0000) begin
        checks++; if (res_data !== T2_RD[c]) begin failures++; $display("FAIL all4_res_data c=%0d got=%h exp=%h", c, res_data, T2_RD[c]); end
        checks++; if (res_id !== T2_ID[c]) begin failures++; $display("FAIL all4_res_id c=%0d got=%0d exp=%0d", c, res_id, T2_ID[c]); end
      end
    end
  endtask

  localparam logic [3:0]  T3_VLD [8] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
  localparam logic [3:0]  T3_GNT [8] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
  localparam logic [3:0]  T3_RV  [8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
  localparam logic [63:0] T3_RD  [8] = '{64'd0, 64'd0, 64'd10, 64'd24, 64'd10, 64'd24, 64'd10, 64'd24};

  task automatic test_back_to_back();
    apply_reset();
    set_req(0, 32'd10, 32'd1);
    set_req(1, 32'd4, 32'd6);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = T3_VLD[c];
      #1;
      checks++; if (req_ready !== T3_GNT[c]) begin failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, T3_GNT[c]); end
      checks++; if (res_valid !== T3_RV[c]) begin failures++; $display("FAIL b2b_res_valid c=%0d got=%b exp=%b", c, res_valid, T3_RV[c]); end
      if (T3_RV[c] != 4'b0000) begin
        checks++; if (res_data !== T3_RD[c]) begin failures++; $display("FAIL b2b_res_data c=%0d got=%h exp=%h", c, res_data, T3_RD[c]); end
      end
    end
  endtask

  task automatic test_busy_bypass();
    apply_reset();
    @(negedge clk);
    set_req(2, 32'hFFFF_FFFF, -32'sd7);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bypass_first got=%b exp=0100", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bypass_busy got=%b exp=0000", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bypass_reissue got=%b exp=0100", req_ready); end
    checks++; if (res_valid !== 4'b0100) begin failures++; $display("FAIL bypass_res_valid got=%b exp=0100", res_valid); end
    checks++; if (res_data !== 64'd7) begin failures++; $display("FAIL bypass_res_data got=%h exp=7", res_data); end
    checks++; if (res_id !== 2'd2) begin failures++; $display("FAIL bypass_res_id got=%0d exp=2", res_id); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    apply_reset();
    @(negedge clk);
    set_req(3, 32'd10, 32'd1);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL midrst_grant got=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++; if (inflight !== 2'd0) begin failures++; $display("FAIL midrst_inflight got=%0d exp=0", inflight); end
    checks++; if (res_data !== 64'd0) begin failures++; $display("FAIL midrst_res_data got=%h exp=0", res_data); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL midrst_res_id got=%0d exp=0", res_id); end
    @(negedge clk);
    #1;
    checks++; if (res_valid !== 4'b0000) begin failures++; $display("FAIL midrst_res_valid got=%b exp=0000", res_valid); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++; if (res_valid !== 4'b0000) begin failures++; $display("FAIL midrst_ghost c=%0d got=%b exp=0000", c, res_valid); end
    end
    @(negedge clk);
    set_req(3, 32'd4, 32'd6);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL midrst_regrant got=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (res_valid !== 4'b1000) begin failures++; $display("FAIL midrst_res2_valid got=%b exp=1000", res_valid); end
    checks++; if (res_data !== 64'd24) begin failures++; $display("FAIL midrst_res2_data got=%h exp=24", res_data); end
    checks++; if (res_id !== 2'd3) begin failures++; $display("FAIL midrst_res2_id got=%0d exp=3", res_id); end
  endtask

  task automatic test_idle();
    apply_reset();
    set_req(0, 32'h1234_5678, 32'h9ABC_DEF0);
    set_req(1, 32'h0000_0001, 32'h0000_0002);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (req_ready !== 4'b0000 || mult_a !== 32'd0 || mult_b !== 32'd0) begin
        failures++; $display("FAIL idle_issue c=%0d ready=%b a=%h b=%h exp 0/0/0", c, req_ready, mult_a, mult_b);
      end
      checks++; if (res_valid !== 4'b0000 || inflight !== 2'd0) begin
        failures++; $display("FAIL idle_result c=%0d res_valid=%b inflight=%0d exp 0/0", c, res_valid, inflight);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_busy_bypass();
    test_reset_midop();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
